// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: conditions a raw mechanical push button for the stack unit.
// The raw level passes through a 2-FF synchronizer. It is then polarity-corrected
// and debounced by a counter-based FSM. The block emits registered single-cycle
// press, release and command pulses. The command pulse can optionally auto-repeat
// while the button is held.
module btn_debounce_pulse #(
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic press_tick,
  output logic release_tick,
  output logic cmd_tick
);

  localparam int CNT_W   = $clog2(DB_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  // Raw level that means "not pressed"; the synchronizer idles at this value.
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_WAIT_PRESS,
    ST_PRESSED,
    ST_WAIT_RELEASE
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;
  logic             r_db;
  logic             r_press;
  logic             r_release;
  logic             r_cmd;

  logic             w_s;
  logic             w_rpt_hit;

  // Pressed-level after synchronization: 1 = pressed, regardless of board polarity.
  assign w_s = r_sync2 ^ IDLE_RAW;

  // Repeat timer reaches its target: the initial delay first, then the period.
  assign w_rpt_hit = (r_rpt_cnt == (r_rpt_first ? DELAY_LAST : PERIOD_LAST));

  // Two-flop synchronizer; reset to the idle level so nothing looks pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= IDLE_RAW;
      r_sync2 <= IDLE_RAW;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with registered level, pulse outputs and the repeat timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RELEASED;
      r_cnt       <= '0;
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
      r_db        <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_cmd       <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cmd     <= 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_s) begin
            r_state <= ST_WAIT_PRESS;
            r_cnt   <= '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!w_s) begin
            r_state <= ST_RELEASED;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_PRESSED;
            r_db        <= 1'b1;
            r_press     <= 1'b1;
            r_cmd       <= 1'b1;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_s) begin
            r_state <= ST_WAIT_RELEASE;
            r_cnt   <= '0;
          end
          // The timer counts every cycle spent here; it resets itself on each hit.
          if (REPEAT_EN != 0) begin
            if (w_rpt_hit) begin
              r_cmd       <= 1'b1;
              r_rpt_cnt   <= '0;
              r_rpt_first <= 1'b0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
            end
          end
        end
        ST_WAIT_RELEASE: begin
          // A return to pressed is a bounce: no pulse and the repeat timer keeps its value.
          if (w_s) begin
            r_state <= ST_PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_RELEASED;
            r_db      <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_RELEASED;
        end
      endcase
    end
  end

  assign db_level     = r_db;
  assign press_tick   = r_press;
  assign release_tick = r_release;
  assign cmd_tick     = r_cmd;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Testbench for btn_debounce_pulse. There are two instances.
// Instance 0 uses an active-low button with auto-repeat enabled.
// Instance 1 uses an active-high button with repeat disabled; it is fed the inverse
// of the raw level, so both see the same presses.
// Expected pulses come from a run-length model of the debounce rule and are queued
// at stimulus time. A negedge monitor pops the queue and compares whenever an
// instance shows a pulse.
module tb_btn_debounce_pulse;

  localparam int DB  = 4;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sw_raw = 1'b1;
  logic sw_hi;
  logic db0, pr0, rl0, cm0;
  logic db1, pr1, rl1, cm1;

  assign sw_hi = ~sw_raw;

  btn_debounce_pulse #(
    .ACTIVE_LOW(1), .DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .sw(sw_raw),
    .db_level(db0), .press_tick(pr0), .release_tick(rl0), .cmd_tick(cm0)
  );

  btn_debounce_pulse #(
    .ACTIVE_LOW(0), .DB_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .sw(sw_hi),
    .db_level(db1), .press_tick(pr1), .release_tick(rl1), .cmd_tick(cm1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int   cyc;
    logic pr;
    logic rl;
    logic cm;
    logic db;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int nchk = 0;
  int npass = 0;
  int cyc = 0;
  int cm_cnt[2];
  int any_cnt = 0;

  // Model state per instance.
  // m_s1/m_s2 is the synchronizer delay.
  // m_lvl is the accepted level.
  // m_run counts consecutive samples that disagree with the accepted level.
  // m_n counts the cycles spent pressed since the accepted press.
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  int m_run[2];
  int m_n[2];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    nchk++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0; m_run[i] = 0; m_n[i] = 0;
    end
  endtask

  // One clock edge of the model; p is the pressed-level present at the edge.
  task automatic model_step(input bit p);
    for (int i = 0; i < 2; i++) begin
      bit s, pr, rl, rp, held;
      ev_t e;
      s = m_s2[i];
      pr = 1'b0; rl = 1'b0; rp = 1'b0;
      held = m_lvl[i] && (m_run[i] == 0);
      if (held && i == 0) begin
        m_n[i]++;
        if (m_n[i] >= DLY && ((m_n[i] - DLY) % PER) == 0) rp = 1'b1;
      end
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB + 1) begin
          m_lvl[i] = s; m_run[i] = 0;
          pr = s; rl = !s;
          if (s) m_n[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = p;
      if (pr || rl || rp) begin
        e.cyc = cyc; e.pr = pr; e.rl = rl; e.cm = pr | rp; e.db = m_lvl[i];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  // Advance one clock edge, then drive the next raw level.
  task automatic tick(input bit v);
    @(posedge clk);
    cyc++;
    if (reset_n) model_step(~sw_raw);
    else model_reset();
    #1;
    sw_raw = v;
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) tick(v);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    model_reset();
    while (q0.size() > 0 && q0[$].cyc >= cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].cyc >= cyc) void'(q1.pop_back());
  endtask

  task automatic mon(input int i, input logic pr, input logic rl, input logic cm, input logic db);
    ev_t e;
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    while (sz > 0) begin
      e = (i == 0) ? q0[0] : q1[0];
      if (e.cyc >= cyc) break;
      fail_now($sformatf("missed_pulse_dut%0d", i), 0, e.cyc);
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      sz--;
    end
    if (pr || rl || cm) begin
      any_cnt++;
      if (cm) cm_cnt[i]++;
      if (sz == 0) begin
        fail_now($sformatf("unexpected_pulse_dut%0d", i), {pr, rl, cm, db}, 0);
      end else begin
        e = (i == 0) ? q0[0] : q1[0];
        if (e.cyc != cyc) begin
          fail_now($sformatf("unexpected_pulse_dut%0d", i), {pr, rl, cm, db}, 0);
        end else begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          chk($sformatf("pulse_pr_rl_cm_db_dut%0d", i), {pr, rl, cm, db}, {e.pr, e.rl, e.cm, e.db});
        end
      end
    end
  endtask

  // Monitor: away from the active edge, compare outputs with the queued expectations.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("outputs_in_reset", {db0, pr0, rl0, cm0, db1, pr1, rl1, cm1}, 0);
    end else begin
      mon(0, pr0, rl0, cm0, db0);
      mon(1, pr1, rl1, cm1, db1);
    end
  end

  initial begin
    int c0, b0, b1, ba;
    cm_cnt[0] = 0; cm_cnt[1] = 0;
    model_reset();
    reset_n = 1'b0;
    sw_raw = 1'b1;
    repeat (3) tick(1'b1);
    reset_n = 1'b1;
    hold(1'b1, 5);

    // Press and hold: level and press pulse appear right after edge 2+DB.
    tick(1'b0);
    c0 = cyc + 1;
    repeat (6) tick(1'b0);
    @(negedge clk);
    chk("press_db_before_edge6", {db0, pr0, db1, pr1}, 0);
    tick(1'b0);
    @(negedge clk);
    chk("press_at_edge6_dut0", {db0, pr0, rl0, cm0}, 4'b1101);
    chk("press_at_edge6_dut1", {db1, pr1, rl1, cm1}, 4'b1101);
    chk("press_edge_index", cyc - c0, 2 + DB);
    hold(1'b0, 4);

    // Release: falling level and release pulse, no command pulse.
    tick(1'b1);
    repeat (6) tick(1'b1);
    @(negedge clk);
    chk("release_before_edge6", {db0, rl0, db1, rl1}, 4'b1010);
    tick(1'b1);
    @(negedge clk);
    chk("release_at_edge6_dut0", {db0, pr0, rl0, cm0}, 4'b0010);
    chk("release_at_edge6_dut1", {db1, pr1, rl1, cm1}, 4'b0010);
    hold(1'b1, 6);

    // Bounce shorter than the debounce window: nothing at all.
    ba = any_cnt;
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 3); hold(1'b1, 12);
    @(negedge clk);
    chk("bounce_pulse_count", any_cnt - ba, 0);
    chk("bounce_level", {db0, db1}, 0);

    // Long hold: press plus repeats at +8, +12 ... +28 on the repeating instance.
    b0 = cm_cnt[0]; b1 = cm_cnt[1];
    tick(1'b0);
    c0 = cyc + 1;
    while (cyc < c0 + 2 + DB + 30) tick(1'b0);
    @(negedge clk);
    chk("repeat_cmd_count_dut0", cm_cnt[0] - b0, 7);
    chk("repeat_cmd_count_dut1", cm_cnt[1] - b1, 1);
    // Short release bounce while held: timer freezes then resumes.
    hold(1'b1, 2); hold(1'b0, 15); hold(1'b1, 12);

    // Reset during the press window with the button held, then a fresh debounce.
    hold(1'b0, 5);
    assert_reset();
    repeat (3) tick(1'b0);
    reset_n = 1'b1;
    c0 = cyc + 1;
    repeat (6) tick(1'b0);
    @(negedge clk);
    chk("post_reset_no_early_press", {pr0, pr1, db0, db1}, 0);
    tick(1'b0);
    @(negedge clk);
    chk("post_reset_press_edge6", {pr0, pr1, db0, db1}, 4'b1111);
    hold(1'b0, 5); hold(1'b1, 12);

    // Randomized runs with occasional resets.
    for (int r = 0; r < 90; r++) begin
      bit v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      hold(v, len);
      if ($urandom_range(0, 24) == 0) begin
        assert_reset();
        repeat (2) tick(v);
        reset_n = 1'b1;
      end
    end

    hold(1'b1, 20);
    @(negedge clk);
    chk("leftover_expected_dut0", q0.size(), 0);
    chk("leftover_expected_dut1", q1.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
